// File: rtl/dev_muldiv_if.sv
// Request and register-file write-back bundle between the sequencer, dev_muldiv and the register file.
interface dev_muldiv_if #(
    parameter int REG_WIDTH  = 64,
    parameter int REG_ADDR_W = 8
);
    logic                  start;
    logic [1:0]            op;
    logic [REG_WIDTH-1:0]  a;
    logic [REG_WIDTH-1:0]  b;
    logic [REG_ADDR_W-1:0] dest;
    logic                  busy;
    logic                  done;
    logic                  div_zero;
    logic                  wr_en;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic [REG_WIDTH-1:0]  wr_data;

    modport master (
        output start, op, a, b, dest,
        input  busy, done, div_zero, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  start, op, a, b, dest,
        output busy, done, div_zero, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/dev_muldiv.sv
// Radix-2 multiply/divide; writes dest at start+W+1 and dest+1 (with done) at start+W+2, divide-by-zero at +1/+2.
// Starts are ignored while busy; signed MULS/DIVS exist only when MULDIV_SIGNED_EN is defined.
module dev_muldiv #(
    parameter int REG_WIDTH  = 64,
    parameter int REG_ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    dev_muldiv_if.slave bus
);
    localparam int W  = REG_WIDTH;
    localparam int CW = $clog2(REG_WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, WB_LO, WB_HI} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  is_div_q, is_div_d;
    logic                  dz_q, dz_d;
    logic [REG_ADDR_W-1:0] dest_q, dest_d;
    logic [W-1:0]          opnd_q, opnd_d;
    logic [2*W-1:0]        acc_q, acc_d;
    logic [W:0]            rem_q, rem_d;

    logic                  wr_en_q, wr_en_d;
    logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [W-1:0]          wr_data_q, wr_data_d;
    logic                  done_q, done_d;
    logic                  div_zero_q, div_zero_d;

`ifdef MULDIV_SIGNED_EN
    logic                  neg_res_q, neg_res_d;
    logic                  neg_rem_q, neg_rem_d;
    logic                  a_neg, b_neg;
`endif

    logic                  op_ok;
    logic [W-1:0]          a_mag, b_mag;
    logic [W:0]            mul_sum;
    logic [W+1:0]          div_trial;
    logic                  div_ok;
    logic [2*W-1:0]        prod;
    logic [W-1:0]          quo, rmd;
    logic [W-1:0]          res_lo, res_hi;

    // Operand conditioning: the iterative core only ever sees magnitudes.
    always_comb begin
        a_mag = bus.a;
        b_mag = bus.b;
`ifdef MULDIV_SIGNED_EN
        a_neg = bus.op[1] & bus.a[W-1];
        b_neg = bus.op[1] & bus.b[W-1];
        if (a_neg) a_mag = -bus.a;
        if (b_neg) b_mag = -bus.b;
        op_ok = 1'b1;
`else
        op_ok = ~bus.op[1];
`endif
    end

    // One iteration step: multiplier sits in acc low half and shifts out LSB first;
    // dividend sits in acc low half and shifts out MSB first into the partial remainder.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? opnd_q : {W{1'b0}})};
        div_trial = {rem_q, acc_q[W-1]} - {2'b00, opnd_q};
        div_ok    = ~div_trial[W+1];
    end

    always_comb begin
        prod = acc_q;
        quo  = acc_q[W-1:0];
        rmd  = rem_q[W-1:0];
`ifdef MULDIV_SIGNED_EN
        if (neg_res_q) begin
            prod = -acc_q;
            quo  = -acc_q[W-1:0];
        end
        if (neg_rem_q) rmd = -rem_q[W-1:0];
`endif
        res_lo = is_div_q ? quo : prod[W-1:0];
        res_hi = is_div_q ? rmd : prod[2*W-1:W];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        dz_d       = dz_q;
        dest_d     = dest_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        rem_d      = rem_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;
`ifdef MULDIV_SIGNED_EN
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start && op_ok) begin
                    is_div_d = bus.op[0];
                    dest_d   = bus.dest;
                    cnt_d    = '0;
                    rem_d    = '0;
                    dz_d     = 1'b0;
                    state_d  = RUN;
`ifdef MULDIV_SIGNED_EN
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg & bus.op[0];
`endif
                    if (bus.op[0]) begin
                        opnd_d = b_mag;
                        acc_d  = {{W{1'b0}}, a_mag};
                        if (bus.b == '0) begin
                            // Divide by zero: results are preloaded, RUN is skipped, no sign fix-up.
                            dz_d    = 1'b1;
                            acc_d   = {{W{1'b0}}, {W{1'b1}}};
                            rem_d   = {1'b0, bus.a};
                            state_d = WB_LO;
`ifdef MULDIV_SIGNED_EN
                            neg_res_d = 1'b0;
                            neg_rem_d = 1'b0;
`endif
                        end
                    end else begin
                        opnd_d = a_mag;
                        acc_d  = {{W{1'b0}}, b_mag};
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (is_div_q) begin
                    acc_d = {acc_q[2*W-1:W], acc_q[W-2:0], div_ok};
                    rem_d = div_ok ? div_trial[W:0] : {rem_q[W-1:0], acc_q[W-1]};
                end else begin
                    acc_d = {mul_sum, acc_q[W-1:1]};
                end
                if (cnt_q == CW'(W - 1)) state_d = WB_LO;
            end
            WB_LO: begin
                wr_en_d   = 1'b1;
                wr_addr_d = dest_q;
                wr_data_d = res_lo;
                state_d   = WB_HI;
            end
            WB_HI: begin
                wr_en_d    = 1'b1;
                wr_addr_d  = dest_q + REG_ADDR_W'(1);
                wr_data_d  = res_hi;
                done_d     = 1'b1;
                div_zero_d = dz_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            dz_q       <= 1'b0;
            dest_q     <= '0;
            opnd_q     <= '0;
            acc_q      <= '0;
            rem_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            dz_q       <= dz_d;
            dest_q     <= dest_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            rem_q      <= rem_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
`ifdef MULDIV_SIGNED_EN
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
`endif
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
endmodule

// File: tb/tb_dev_muldiv.sv
// Bench for dev_muldiv: arithmetic reference model with per-cycle output compare, directed cases and random traffic.
module tb_dev_muldiv;
    localparam int W  = 64;
    localparam int AW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    dev_muldiv_if #(.REG_WIDTH(W), .REG_ADDR_W(AW)) bus ();
    dev_muldiv #(.REG_WIDTH(W), .REG_ADDR_W(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference arithmetic straight from the operation definitions.
    function automatic void model_result(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                         output logic [W-1:0] lo, output logic [W-1:0] hi, output logic dz);
        logic [2*W-1:0] p;
        dz = 1'b0;
        lo = '0;
        hi = '0;
        case (op)
            2'd0: begin
                p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                lo = p[W-1:0];
                hi = p[2*W-1:W];
            end
            2'd1: begin
                if (b == 0) begin lo = '1; hi = a; dz = 1'b1; end
                else begin lo = a / b; hi = a % b; end
            end
`ifdef MULDIV_SIGNED_EN
            2'd2: begin
                p  = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
                lo = p[W-1:0];
                hi = p[2*W-1:W];
            end
            2'd3: begin
                if (b == 0) begin lo = '1; hi = a; dz = 1'b1; end
                else if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin lo = a; hi = '0; end
                else begin lo = $signed(a) / $signed(b); hi = $signed(a) % $signed(b); end
            end
`endif
            default: ;
        endcase
    endfunction

    // Model timeline: one request at a time, expected write cycles derived from the accept cycle.
    int cyc = 0, free_at = 0, busy_end = -1, lo_cyc = -1, hi_cyc = -1, acc_cyc = -1;
    logic [AW-1:0] e_dest;
    logic [W-1:0]  e_lo, e_hi;
    logic          e_dz;

    always @(posedge clk) begin
        logic [W-1:0] lo, hi;
        logic dz, valid;
        int lat;
        cyc++;
        if (!rst_n) begin
            busy_end = -1; lo_cyc = -1; hi_cyc = -1; free_at = 0;
        end else if (bus.start && cyc >= free_at) begin
`ifdef MULDIV_SIGNED_EN
            valid = 1'b1;
`else
            valid = (bus.op < 2);
`endif
            if (valid) begin
                model_result(bus.op, bus.a, bus.b, lo, hi, dz);
                lat      = dz ? 1 : W + 1;
                e_lo     = lo; e_hi = hi; e_dz = dz; e_dest = bus.dest;
                acc_cyc  = cyc;
                lo_cyc   = cyc + lat;
                hi_cyc   = lo_cyc + 1;
                busy_end = lo_cyc;
                free_at  = cyc + lat + 2;
            end
        end
    end

    logic [AW-1:0] wq_addr[$];
    logic [W-1:0]  wq_data[$];
    int            wq_cyc[$];
    logic          wq_done[$];
    logic          wq_dz[$];

    always @(negedge clk) begin
        logic ew;
        if (cyc >= 1) begin
            ew = (cyc == lo_cyc) || (cyc == hi_cyc);
            check("busy", bus.busy, cyc <= busy_end);
            check("wr_en", bus.wr_en, ew);
            check("done", bus.done, cyc == hi_cyc);
            check("div_zero", bus.div_zero, (cyc == hi_cyc) && e_dz);
            if (ew) begin
                check("wr_addr", bus.wr_addr, (cyc == lo_cyc) ? e_dest : AW'(e_dest + 1));
                check("wr_data", bus.wr_data, (cyc == lo_cyc) ? e_lo : e_hi);
            end
            if (bus.wr_en) begin
                wq_addr.push_back(bus.wr_addr);
                wq_data.push_back(bus.wr_data);
                wq_cyc.push_back(cyc);
                wq_done.push_back(bus.done);
                wq_dz.push_back(bus.div_zero);
            end
        end
    end

    task automatic clear_log();
        wq_addr.delete(); wq_data.delete(); wq_cyc.delete(); wq_done.delete(); wq_dz.delete();
    endtask

    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic [AW-1:0] d);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.dest = d;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic expect_pair(input string nm, input logic [AW-1:0] a0, input logic [W-1:0] d0,
                               input logic [AW-1:0] a1, input logic [W-1:0] d1, input int off, input logic dz);
        int k = 0;
        while (wq_addr.size() < 2 && k < 200) begin
            @(negedge clk); #1; k++;
        end
        if (wq_addr.size() < 2) begin
            checks++; errors++;
            $display("FAIL %s timeout: %0d writes seen, 2 required", nm, wq_addr.size());
        end else begin
            check({nm, " lo_addr"}, wq_addr[0], a0);
            check({nm, " lo_data"}, wq_data[0], d0);
            check({nm, " lo_cycle"}, wq_cyc[0] - acc_cyc, off);
            check({nm, " hi_addr"}, wq_addr[1], a1);
            check({nm, " hi_data"}, wq_data[1], d1);
            check({nm, " done_cycle"}, wq_cyc[1] - acc_cyc, off + 1);
            check({nm, " done"}, wq_done[1], 1'b1);
            check({nm, " div_zero"}, wq_dz[1], dz);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] lo, hi;
        logic dz;
        bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.dest = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst busy", bus.busy, 1'b0);
        check("rst done", bus.done, 1'b0);
        check("rst div_zero", bus.div_zero, 1'b0);
        check("rst wr_en", bus.wr_en, 1'b0);
        check("rst wr_addr", bus.wr_addr, '0);
        check("rst wr_data", bus.wr_data, '0);

        model_result(2'd0, 64'h1_0000_0000, 64'h1_0000_0000, lo, hi, dz);
        check("model mul 2^64", {hi, lo}, {64'd1, 64'd0});
        model_result(2'd1, 64'd100, 64'd7, lo, hi, dz);
        check("model div 100/7", {hi, lo}, {64'd2, 64'd14});

        rst_n = 1'b1;
        clear_log(); issue(2'd0, 64'd7, 64'd6, 8'd5);
        expect_pair("mul7x6", 8'd5, 64'd42, 8'd6, 64'd0, W + 1, 1'b0);
        clear_log(); issue(2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 8'd10);
        expect_pair("mul_max_x2", 8'd10, 64'hFFFF_FFFF_FFFF_FFFE, 8'd11, 64'd1, W + 1, 1'b0);
        clear_log(); issue(2'd1, 64'd100, 64'd7, 8'd255);
        expect_pair("div100_7_wrap", 8'd255, 64'd14, 8'd0, 64'd2, W + 1, 1'b0);
        clear_log(); issue(2'd1, 64'd123, 64'd0, 8'd3);
        expect_pair("div_by_zero", 8'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'd4, 64'd123, 1, 1'b1);
        clear_log(); issue(2'd0, 64'd5, 64'd5, 8'd0);
        expect_pair("dest0", 8'd0, 64'd25, 8'd1, 64'd0, W + 1, 1'b0);

        clear_log(); issue(2'd0, 64'd1000, 64'd3, 8'd20);
        repeat (10) @(negedge clk);
        issue(2'd1, 64'd77, 64'd5, 8'd40);
        expect_pair("start_while_busy", 8'd20, 64'd3000, 8'd21, 64'd0, W + 1, 1'b0);

        clear_log(); issue(2'd0, 64'd12345, 64'd678, 8'd7);
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort busy", bus.busy, 1'b0);
        repeat (80) @(negedge clk);
        #1;
        check("abort writes", wq_addr.size(), 0);
        clear_log(); issue(2'd0, 64'd3, 64'd3, 8'd9);
        expect_pair("mul3x3_after_rst", 8'd9, 64'd9, 8'd10, 64'd0, W + 1, 1'b0);

`ifndef MULDIV_SIGNED_EN
        clear_log(); issue(2'd2, 64'd5, 64'd5, 8'd1);
        check("reserved busy", bus.busy, 1'b0);
        repeat (70) @(negedge clk);
        #1;
        check("reserved writes", wq_addr.size(), 0);
`endif

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            bus.start = ($urandom_range(0, 3) == 0);
            bus.op    = 2'($urandom_range(0, 3));
            bus.a     = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       bus.b = '0;
                1:       bus.b = 64'($urandom_range(1, 15));
                2:       bus.b = {$urandom, $urandom};
                default: bus.b = {32'd0, $urandom};
            endcase
            bus.dest  = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
            rst_n     = (i != 2000);
        end
        bus.start = 1'b0;
        rst_n     = 1'b1;
        repeat (80) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
